// File: rtl/cpu_run_controller.sv
// Load/run/dump sequencer: streams a program image into byte RAM, runs the CPU
// until a PC limit or cycle budget, then streams a RAM window back as big-endian words.
module cpu_run_controller #(
   parameter int ADDR_W     = 8,
   parameter int WORD_BYTES = 4,
   parameter int DUMP_WORDS = 64,
   parameter int PC_LIMIT   = 24,
   parameter int WARMUP     = 4,
   parameter int MAX_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    start,
   input  logic                    load_valid,
   input  logic [7:0]              load_data,
   input  logic                    load_last,
   output logic                    load_ready,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [7:0]              mem_wdata,
   output logic                    mem_we,
   input  logic [7:0]              mem_rdata,
   input  logic [31:0]             pc,
   output logic                    cpu_clr,
   output logic                    cpu_run,
   output logic                    dump_valid,
   output logic [ADDR_W-1:0]       dump_addr,
   output logic [8*WORD_BYTES-1:0] dump_data,
   input  logic                    dump_ready,
   output logic [31:0]             run_cycles,
   output logic                    timeout,
   output logic                    load_full,
   output logic                    done
);

   localparam int DUMP_W = 8 * WORD_BYTES;
   localparam int RD_W   = $clog2(WORD_BYTES + 1);
   localparam int WC_W   = $clog2(DUMP_WORDS + 1);

   localparam logic [31:0]       WARMUP_C     = 32'(WARMUP);
   localparam logic [31:0]       PC_LIMIT_C   = 32'(PC_LIMIT);
   localparam logic [31:0]       LAST_CYCLE_C = 32'(MAX_CYCLES - 1);
   localparam logic [RD_W-1:0]   RD_LAST      = RD_W'(WORD_BYTES);
   localparam logic [WC_W-1:0]   WC_LAST      = WC_W'(DUMP_WORDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP    = ADDR_W'(WORD_BYTES);

   typedef enum logic [2:0] {
      IDLE, LOAD, CPURST, RUN, DRD, DOUT, DONE
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic [ADDR_W-1:0]   base, base_nxt;
   logic [RD_W-1:0]     rd_cnt, rd_cnt_nxt;
   logic [WC_W-1:0]     word_cnt, word_cnt_nxt;
   logic [DUMP_W-1:0]   word, word_nxt;
   logic [31:0]         run_cycles_nxt;
   logic                timeout_nxt;
   logic                load_full_nxt;

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         ptr        <= '0;
         base       <= '0;
         rd_cnt     <= '0;
         word_cnt   <= '0;
         word       <= '0;
         run_cycles <= '0;
         timeout    <= 1'b0;
         load_full  <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         base       <= base_nxt;
         rd_cnt     <= rd_cnt_nxt;
         word_cnt   <= word_cnt_nxt;
         word       <= word_nxt;
         run_cycles <= run_cycles_nxt;
         timeout    <= timeout_nxt;
         load_full  <= load_full_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      ptr_nxt        = ptr;
      base_nxt       = base;
      rd_cnt_nxt     = rd_cnt;
      word_cnt_nxt   = word_cnt;
      word_nxt       = word;
      run_cycles_nxt = run_cycles;
      timeout_nxt    = timeout;
      load_full_nxt  = load_full;
      load_ready     = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      cpu_clr        = 1'b1;
      cpu_run        = 1'b0;
      dump_valid     = 1'b0;
      done           = 1'b0;

      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               state_nxt      = LOAD;
               ptr_nxt        = '0;
               run_cycles_nxt = '0;
               timeout_nxt    = 1'b0;
               load_full_nxt  = 1'b0;
            end
         end

         LOAD: begin
            load_ready = 1'b1;
            mem_addr   = ptr;
            if (load_valid) begin
               mem_we    = 1'b1;
               mem_wdata = load_data;
               ptr_nxt   = ptr + 1'b1;
               if (load_last) begin
                  state_nxt = CPURST;
               end else if (ptr == '1) begin
                  load_full_nxt = 1'b1;
                  state_nxt     = CPURST;
               end
            end
         end

         CPURST: state_nxt = RUN;

         RUN: begin
            cpu_clr = 1'b0;
            cpu_run = 1'b1;
            if (run_cycles != '1) begin
               run_cycles_nxt = run_cycles + 32'd1;
            end
            // Checks use the pre-increment count; the pc stop outranks the budget.
            if (run_cycles >= WARMUP_C) begin
               if (pc > PC_LIMIT_C) begin
                  state_nxt = DRD;
               end else if (run_cycles >= LAST_CYCLE_C) begin
                  timeout_nxt = 1'b1;
                  state_nxt   = DRD;
               end
            end
            if (state_nxt == DRD) begin
               base_nxt     = '0;
               rd_cnt_nxt   = '0;
               word_cnt_nxt = '0;
            end
         end

         // rd_cnt runs one past the last address so the final byte can be captured.
         DRD: begin
            mem_addr = base + ADDR_W'(rd_cnt);
            if (rd_cnt != '0) begin
               word_nxt = (word << 8) | DUMP_W'(mem_rdata);
            end
            if (rd_cnt == RD_LAST) begin
               state_nxt = DOUT;
            end else begin
               rd_cnt_nxt = rd_cnt + 1'b1;
            end
         end

         DOUT: begin
            dump_valid = 1'b1;
            if (dump_ready) begin
               base_nxt     = base + ADDR_STEP;
               word_cnt_nxt = word_cnt + 1'b1;
               rd_cnt_nxt   = '0;
               state_nxt    = (word_cnt == WC_LAST) ? DONE : DRD;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign dump_addr = base;
   assign dump_data = word;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a byte RAM model and a simple PC generator.
module tb_cpu_run_controller;

   localparam int ADDR_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int DUMP_WORDS = 64;

   logic                    clk = 1'b0;
   logic                    clr;
   logic                    start;
   logic                    load_valid;
   logic [7:0]              load_data;
   logic                    load_last;
   logic                    load_ready;
   logic [ADDR_W-1:0]       mem_addr;
   logic [7:0]              mem_wdata;
   logic                    mem_we;
   logic [7:0]              mem_rdata;
   logic [31:0]             pc;
   logic                    cpu_clr;
   logic                    cpu_run;
   logic                    dump_valid;
   logic [ADDR_W-1:0]       dump_addr;
   logic [8*WORD_BYTES-1:0] dump_data;
   logic                    dump_ready;
   logic [31:0]             run_cycles;
   logic                    timeout;
   logic                    load_full;
   logic                    done;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] ram [256];
   logic [7:0] exp_mem [256];
   bit         ram_primed = 1'b0;
   int         we_count = 0;
   int         cyc = 0;
   bit         pc_mode = 1'b0;

   cpu_run_controller #(
      .ADDR_W(ADDR_W), .WORD_BYTES(WORD_BYTES), .DUMP_WORDS(DUMP_WORDS),
      .PC_LIMIT(24), .WARMUP(4), .MAX_CYCLES(1024)
   ) dut (
      .clk(clk), .clr(clr), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .pc(pc), .cpu_clr(cpu_clr), .cpu_run(cpu_run),
      .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
      .dump_ready(dump_ready),
      .run_cycles(run_cycles), .timeout(timeout), .load_full(load_full), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM, primed with a known pattern on the first edge.
   always @(posedge clk) begin
      if (!ram_primed) begin
         for (int a = 0; a < 256; a++) ram[a] <= 8'(a * 37 + 5);
         ram_primed <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
      if (mem_we) we_count <= we_count + 1;
   end

   // CPU stand-in: mode 0 ramps pc by 4 per run cycle, mode 1 spikes to 100 then sticks at 0.
   always @(posedge clk) begin
      if (cpu_clr) cyc <= 0;
      else if (cpu_run) cyc <= cyc + 1;
   end
   assign pc = pc_mode ? ((cyc < 4) ? 32'd100 : 32'd0) : 32'(cyc * 4);

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_load_ready"}, 32'(load_ready), 32'd0);
      checkOutput({tag, "_mem_we"},     32'(mem_we),     32'd0);
      checkOutput({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
      checkOutput({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
      checkOutput({tag, "_cpu_clr"},    32'(cpu_clr),    32'd1);
      checkOutput({tag, "_cpu_run"},    32'(cpu_run),    32'd0);
      checkOutput({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
      checkOutput({tag, "_dump_addr"},  32'(dump_addr),  32'd0);
      checkOutput({tag, "_dump_data"},  dump_data,       32'd0);
      checkOutput({tag, "_run_cycles"}, run_cycles,      32'd0);
      checkOutput({tag, "_timeout"},    32'(timeout),    32'd0);
      checkOutput({tag, "_load_full"},  32'(load_full),  32'd0);
      checkOutput({tag, "_done"},       32'(done),       32'd0);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Streams count bytes into LOAD, optionally idling every other cycle, then
   // checks the single CPURST cycle and the first RUN cycle.
   task automatic applyStimulus(input int count, input int seed, input bit gaps,
                                input bit mark_last);
      logic [7:0] b;
      for (int j = 0; j < count; j++) begin
         if (gaps) begin
            load_valid = 1'b0;
            #1;
            checkOutput($sformatf("gap_we_%0d", j), 32'(mem_we), 32'd0);
            @(negedge clk);
         end
         b = 8'(seed + 13 * j);
         load_valid = 1'b1;
         load_data  = b;
         load_last  = mark_last && (j == count - 1);
         #1;
         checkOutput($sformatf("load_we_%0d", j), 32'(mem_we), 32'd1);
         checkOutput($sformatf("load_addr_%0d", j), 32'(mem_addr), 32'(j % 256));
         checkOutput($sformatf("load_wdata_%0d", j), 32'(mem_wdata), 32'(b));
         exp_mem[j % 256] = b;
         @(negedge clk);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
      checkOutput("cpurst_load_ready", 32'(load_ready), 32'd0);
      checkOutput("cpurst_cpu_clr", 32'(cpu_clr), 32'd1);
      checkOutput("cpurst_cpu_run", 32'(cpu_run), 32'd0);
      @(negedge clk);
      checkOutput("run0_cpu_run", 32'(cpu_run), 32'd1);
   endtask

   task automatic countRun(output int n);
      n = 0;
      while (cpu_run === 1'b1 && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic dumpAll(input int stall_word);
      int         n;
      logic [7:0] a;
      logic [31:0] expw;
      dump_ready = 1'b1;
      for (int w = 0; w < DUMP_WORDS; w++) begin
         if (w == stall_word) dump_ready = 1'b0;
         n = 0;
         while (dump_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         a = 8'(4 * w);
         expw = {exp_mem[a], exp_mem[8'(a + 8'd1)], exp_mem[8'(a + 8'd2)], exp_mem[8'(a + 8'd3)]};
         checkOutput($sformatf("dump_gap_%0d", w), 32'(n), 32'd5);
         checkOutput($sformatf("dump_addr_%0d", w), 32'(dump_addr), 32'(a));
         checkOutput($sformatf("dump_data_%0d", w), dump_data, expw);
         if (w == stall_word) begin
            repeat (4) begin
               @(negedge clk);
               checkOutput("stall_valid", 32'(dump_valid), 32'd1);
               checkOutput("stall_addr", 32'(dump_addr), 32'(a));
               checkOutput("stall_data", dump_data, expw);
            end
            dump_ready = 1'b1;
         end
         @(negedge clk);
      end
      checkOutput("dump_done", 32'(done), 32'd1);
      checkOutput("dump_done_valid", 32'(dump_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int w0;
      clr        = 1'b1;
      start      = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      dump_ready = 1'b1;
      for (int a = 0; a < 256; a++) exp_mem[a] = 8'(a * 37 + 5);

      repeat (2) @(negedge clk);
      checkResetValues("reset");
      clr = 1'b0;
      @(negedge clk);
      checkOutput("idle_load_ready", 32'(load_ready), 32'd0);

      // 32-byte image, pc ramp: stop after the pc=28 cycle (k=7), 8 run cycles.
      pulseStart();
      checkOutput("load_state_ready", 32'(load_ready), 32'd1);
      w0 = we_count;
      applyStimulus(32, 16, 1'b0, 1'b1);
      checkOutput("we_cycles", 32'(we_count - w0), 32'd32);
      for (int j = 0; j < 32; j++)
         checkOutput($sformatf("ram_%0d", j), 32'(ram[j]), 32'(exp_mem[j]));
      pc_mode = 1'b0;
      countRun(n);
      checkOutput("ramp_run_len", 32'(n), 32'd8);
      checkOutput("ramp_run_cycles", run_cycles, 32'd8);
      checkOutput("ramp_timeout", 32'(timeout), 32'd0);
      checkOutput("ramp_load_full", 32'(load_full), 32'd0);
      dumpAll(2);

      // Gapped load from DONE, early pc spike ignored, budget timeout, clr mid-DOUT.
      pulseStart();
      checkOutput("restart_run_cycles", run_cycles, 32'd0);
      checkOutput("restart_timeout", 32'(timeout), 32'd0);
      applyStimulus(8, 200, 1'b1, 1'b1);
      for (int j = 0; j < 8; j++)
         checkOutput($sformatf("gap_ram_%0d", j), 32'(ram[j]), 32'(exp_mem[j]));
      pc_mode = 1'b1;
      countRun(n);
      checkOutput("to_run_len", 32'(n), 32'd1024);
      checkOutput("to_run_cycles", run_cycles, 32'd1024);
      checkOutput("to_timeout", 32'(timeout), 32'd1);
      dump_ready = 1'b0;
      n = 0;
      while (dump_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("to_dump_valid", 32'(dump_valid), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      checkResetValues("clr_dout");
      clr = 1'b0;

      // start coinciding with clr is dropped.
      clr   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("clr_start_load_ready", 32'(load_ready), 32'd0);

      // clr mid-RUN.
      pulseStart();
      applyStimulus(4, 77, 1'b0, 1'b1);
      pc_mode = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midrun_cpu_run", 32'(cpu_run), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      checkResetValues("clr_run");
      clr = 1'b0;

      // Full 256-byte image with no load_last sets load_full, then a complete run and dump.
      pulseStart();
      applyStimulus(256, 3, 1'b0, 1'b0);
      checkOutput("full_flag", 32'(load_full), 32'd1);
      countRun(n);
      checkOutput("full_run_len", 32'(n), 32'd8);
      checkOutput("full_run_cycles", run_cycles, 32'd8);
      checkOutput("full_timeout", 32'(timeout), 32'd0);
      dumpAll(63);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
